// File: rtl/rx_pair_packer.sv
// rtl/rx_pair_packer.sv - I/Q pair packer into a FWFT word FIFO; optional window header via RX_HEADER_EN
module rx_pair_packer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  gate,
  input  logic                  strobe,
  input  logic [15:0]           i_in,
  input  logic [15:0]           q_in,
  input  logic                  rd_en,
  output logic [15:0]           dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clear_overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef RX_HEADER_EN
  typedef enum logic [1:0] {IDLE, WR_I, WR_Q} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR_Q} state_t;
`endif

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overrun_q;
  logic [15:0]             q_lat_q;
  logic [15:0]             mem [DEPTH];

  logic                    qs;
  logic                    pop;
  logic                    wr_en;
  logic [15:0]             wr_data;
  logic                    latch;
  logic                    ovr_set;

`ifdef RX_HEADER_EN
  logic [15:0]             i_lat_q;
  logic                    gate_q;
  logic                    hdr_pend_q;
  logic [7:0]              win_cnt_q;
  logic                    hdr_clr;
`endif

  assign qs  = strobe & enable & gate;
  assign pop = rd_en & (count_q != '0);

  // Room is reserved for the whole pair up front, so WR_I/WR_Q never need a space check.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    latch   = 1'b0;
    ovr_set = 1'b0;
`ifdef RX_HEADER_EN
    hdr_clr = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (qs) begin
`ifdef RX_HEADER_EN
          if (hdr_pend_q) begin
            if (int'(count_q) <= DEPTH - 3) begin
              wr_en   = 1'b1;
              wr_data = {8'hA5, win_cnt_q};
              latch   = 1'b1;
              hdr_clr = 1'b1;
              state_d = WR_I;
            end else begin
              ovr_set = 1'b1;
            end
          end else
`endif
          if (int'(count_q) <= DEPTH - 2) begin
            wr_en   = 1'b1;
            wr_data = i_in;
            latch   = 1'b1;
            state_d = WR_Q;
          end else begin
            ovr_set = 1'b1;
          end
        end
      end
`ifdef RX_HEADER_EN
      WR_I: begin
        wr_en   = 1'b1;
        wr_data = i_lat_q;
        ovr_set = qs;
        state_d = WR_Q;
      end
`endif
      WR_Q: begin
        wr_en   = 1'b1;
        wr_data = q_lat_q;
        ovr_set = qs;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      q_lat_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (latch) q_lat_q  <= q_in;
      if (ovr_set)            overrun_q <= 1'b1;
      else if (clear_overrun) overrun_q <= 1'b0;
    end
  end

`ifdef RX_HEADER_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_lat_q    <= 16'h0000;
      gate_q     <= 1'b0;
      hdr_pend_q <= 1'b0;
      win_cnt_q  <= 8'h00;
    end else begin
      gate_q <= gate;
      if (latch) i_lat_q <= i_in;
      if (hdr_clr) win_cnt_q <= win_cnt_q + 8'd1;
      if (gate && !gate_q && enable) hdr_pend_q <= 1'b1;
      else if (hdr_clr)              hdr_pend_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign count   = count_q;
  assign overrun = overrun_q;
  assign dout    = empty ? 16'h0000 : mem[rd_ptr_q];

endmodule
